// File: rtl/uio_bus_scheduler.sv
// uio_bus_scheduler
//   Round-robin owner arbitration for the shared 8-bit uio pad bank. One
//   requester at a time owns the pads. Its data and per-bit enables are muxed
//   onto uio_out/uio_oe. Each tenure is capped at MAX_BURST beats, and an
//   all-input turnaround gap of TURNAROUND cycles follows every release.
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   ena      tt enable; low forces release and idle
//   req      per-requester request, held high for the whole tenure
//   last     per-requester final-beat flag
//   dout     requester i pad data in bits [8i+7:8i]
//   doe      requester i pad output enables, same slicing
//   grant    registered one-hot grant
//   owner    index of the current/most recent owner
//   busy     high in GRANT or TURN
//   uio_out  muxed pad data (zero unless granted)
//   uio_oe   muxed pad enables (zero unless granted)
module uio_bus_scheduler #(
  parameter int NREQ       = 4,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [8*NREQ-1:0] dout,
  input  logic [8*NREQ-1:0] doe,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        owner,
  output logic              busy,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] BEAT_LAST = 8'(MAX_BURST - 1);
  localparam logic [2:0] TURN_LAST = (TURNAROUND > 0) ? 3'(TURNAROUND - 1) : 3'd0;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [7:0]      beat_q, beat_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      tcnt_q, tcnt_d;

  logic            found;
  logic [2:0]      pick;
  logic [NREQ-1:0] pick_oh;
  logic            own_req, own_last;
  logic [7:0]      own_dout, own_doe;
  logic            rel;
  logic [2:0]      ptr_next;

  // Rotating-priority search: the first set request at or after ptr wins.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && (j == (32'(ptr_q) + i) % NREQ) && req[j]) begin
          found      = 1'b1;
          pick       = 3'(j);
          pick_oh    = '0;
          pick_oh[j] = 1'b1;
        end
      end
    end
  end

  // Owner-indexed views of the request-side inputs.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_dout = '0;
    own_doe  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = req[i];
        own_last = last[i];
        own_dout = dout[8*i +: 8];
        own_doe  = doe[8*i +: 8];
      end
    end
  end

  assign rel      = !own_req || own_last || (beat_q == BEAT_LAST) || !ena;
  assign ptr_next = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    owner_d = owner_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (ena && found) begin
          state_d = GRANT;
          grant_d = pick_oh;
          owner_d = pick;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          tcnt_d  = '0;
          state_d = (TURNAROUND > 0 && ena) ? TURN : IDLE;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      TURN: begin
        if (!ena || tcnt_q == TURN_LAST) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      beat_q  <= '0;
      grant_q <= '0;
      owner_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);
  assign uio_out = (state_q == GRANT) ? own_dout : '0;
  assign uio_oe  = (state_q == GRANT) ? own_doe  : '0;

endmodule
